// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: widths, ALU opcodes and the arbiter FSM encoding.
package alu_pkg;

  localparam int unsigned DW  = 16;
  localparam int unsigned OPW = 5;

  localparam logic [OPW-1:0] OpAdd = 5'd0;
  localparam logic [OPW-1:0] OpAdc = 5'd1;
  localparam logic [OPW-1:0] OpSub = 5'd2;
  localparam logic [OPW-1:0] OpInc = 5'd3;
  localparam logic [OPW-1:0] OpDec = 5'd4;
  localparam logic [OPW-1:0] OpAnd = 5'd5;
  localparam logic [OPW-1:0] OpOr  = 5'd6;
  localparam logic [OPW-1:0] OpXor = 5'd7;
  localparam logic [OPW-1:0] OpNot = 5'd8;
  localparam logic [OPW-1:0] OpCmp = 5'd9;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StCapture,
    StResp
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: priority search starting at a stored pointer, wrapping, one-hot grant.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned IdxW = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               ptr_we_i,
  input  logic [IdxW-1:0]    ptr_wdata_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IdxW-1:0]    gnt_idx_o
);

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic            found;
  int unsigned     idx;
  logic [IdxW-1:0] idx_w;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = 0;
    idx_w     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_w = IdxW'(idx);
      if (!found && req_i[idx_w]) begin
        found         = 1'b1;
        gnt_o[idx_w]  = 1'b1;
        gnt_idx_o     = idx_w;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_we_i ? ptr_wdata_i : ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between NUM_REQ requesters, one op in flight, round-robin.
// Optional ALU_LOCK_EN adds req_lock so a requester can keep the ALU for a carry chain.
module alu_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned DW      = alu_pkg::DW,
  parameter int unsigned OPW     = alu_pkg::OPW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*OPW-1:0] req_opcode,
  input  logic [NUM_REQ*DW-1:0]  req_a,
  input  logic [NUM_REQ*DW-1:0]  req_b,
`ifdef ALU_LOCK_EN
  input  logic [NUM_REQ-1:0]     req_lock,
`endif
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [DW-1:0]          rsp_data,
  output logic                   rsp_cflag,
  output logic                   rsp_zflag,
  output logic                   rsp_sflag,
  output logic                   alu_enable,
  output logic [OPW-1:0]         alu_opcode,
  output logic [DW-1:0]          alu_in_a,
  output logic [DW-1:0]          alu_in_b,
  input  logic [DW-1:0]          alu_out,
  input  logic                   alu_cflag
);

  import alu_pkg::*;

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  state_e             state_q, state_d;
  logic [IdxW-1:0]    win_q, win_d, win_inc;
  logic [OPW-1:0]     op_q, op_d;
  logic [DW-1:0]      a_q, a_d, b_q, b_d;
  logic               alu_en_q, alu_en_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]      rsp_data_q, rsp_data_d;
  logic               rsp_c_q, rsp_c_d, rsp_z_q, rsp_z_d, rsp_s_q, rsp_s_d;
  logic [NUM_REQ-1:0] rr_gnt, grant;
  logic [IdxW-1:0]    rr_gnt_idx, grant_idx;
  logic               ptr_we, hs;
`ifdef ALU_LOCK_EN
  logic               lock_q, lock_d, lock_act_q, lock_act_d;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_valid),
    .ptr_we_i    (ptr_we),
    .ptr_wdata_i (win_inc),
    .gnt_o       (rr_gnt),
    .gnt_idx_o   (rr_gnt_idx)
  );

  assign win_inc = (win_q == IdxW'(NUM_REQ - 1)) ? '0 : win_q + IdxW'(1);

  always_comb begin
    grant     = rr_gnt;
    grant_idx = rr_gnt_idx;
`ifdef ALU_LOCK_EN
    // The pointer already sits at winner+1, so falling through here resumes round-robin there.
    if (lock_act_q && req_valid[win_q]) begin
      grant        = '0;
      grant[win_q] = 1'b1;
      grant_idx    = win_q;
    end
`endif
    req_ready = (state_q == StIdle) ? grant : '0;
    hs        = |(req_valid & req_ready);
  end

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    alu_en_d    = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_c_d     = rsp_c_q;
    rsp_z_d     = rsp_z_q;
    rsp_s_d     = rsp_s_q;
    ptr_we      = 1'b0;
`ifdef ALU_LOCK_EN
    lock_d      = lock_q;
    lock_act_d  = lock_act_q;
`endif
    unique case (state_q)
      StIdle: begin
`ifdef ALU_LOCK_EN
        lock_act_d = 1'b0;
`endif
        if (hs) begin
          win_d    = grant_idx;
          op_d     = req_opcode[grant_idx*OPW +: OPW];
          a_d      = req_a[grant_idx*DW +: DW];
          b_d      = req_b[grant_idx*DW +: DW];
          alu_en_d = 1'b1;
`ifdef ALU_LOCK_EN
          lock_d   = req_lock[grant_idx];
`endif
          state_d  = StIssue;
        end
      end
      StIssue: state_d = StCapture;
      StCapture: begin
        rsp_data_d  = alu_out;
        rsp_c_d     = alu_cflag;
        rsp_z_d     = (alu_out == '0);
        rsp_s_d     = alu_out[DW-1];
        rsp_valid_d = NUM_REQ'(1) << win_q;
        state_d     = StResp;
      end
      StResp: begin
        if (rsp_ready[win_q]) begin
          rsp_valid_d = '0;
          ptr_we      = 1'b1;
`ifdef ALU_LOCK_EN
          lock_act_d  = lock_q;
`endif
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      win_q       <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      alu_en_q    <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_c_q     <= 1'b0;
      rsp_z_q     <= 1'b0;
      rsp_s_q     <= 1'b0;
`ifdef ALU_LOCK_EN
      lock_q      <= 1'b0;
      lock_act_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      alu_en_q    <= alu_en_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_c_q     <= rsp_c_d;
      rsp_z_q     <= rsp_z_d;
      rsp_s_q     <= rsp_s_d;
`ifdef ALU_LOCK_EN
      lock_q      <= lock_d;
      lock_act_q  <= lock_act_d;
`endif
    end
  end

  assign alu_enable = alu_en_q;
  assign alu_opcode = op_q;
  assign alu_in_a   = a_q;
  assign alu_in_b   = b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_cflag  = rsp_c_q;
  assign rsp_zflag  = rsp_z_q;
  assign rsp_sflag  = rsp_s_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural registered ALU; covers ALU_LOCK_EN builds.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [9:0]  req_opcode;
  logic [31:0] req_a, req_b;
  logic [1:0]  req_lock;
  logic [15:0] rsp_data, alu_in_a, alu_in_b;
  logic        rsp_cflag, rsp_zflag, rsp_sflag, alu_enable;
  logic [4:0]  alu_opcode;
  logic [15:0] alu_out_m = 16'h0;
  logic        alu_c_m = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(
    .NUM_REQ (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_a      (req_a),
    .req_b      (req_b),
`ifdef ALU_LOCK_EN
    .req_lock   (req_lock),
`endif
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_cflag  (rsp_cflag),
    .rsp_zflag  (rsp_zflag),
    .rsp_sflag  (rsp_sflag),
    .alu_enable (alu_enable),
    .alu_opcode (alu_opcode),
    .alu_in_a   (alu_in_a),
    .alu_in_b   (alu_in_b),
    .alu_out    (alu_out_m),
    .alu_cflag  (alu_c_m)
  );

  // Registered ALU: result and carry appear the cycle after an enabled cycle.
  function automatic logic [16:0] alu_eval(input logic [4:0] op, input logic [15:0] a, b,
                                           input logic ci, input logic [15:0] prev);
    logic [16:0] t;
    case (op)
      OpAdd:   t = {1'b0, a} + {1'b0, b};
      OpAdc:   t = {1'b0, a} + {1'b0, b} + {16'h0, ci};
      OpSub:   t = {1'b0, a} - {1'b0, b};
      OpInc:   t = {1'b0, a} + 17'd1;
      OpDec:   t = {1'b0, a} - 17'd1;
      OpAnd:   t = {ci, a & b};
      OpOr:    t = {ci, a | b};
      OpXor:   t = {ci, a ^ b};
      OpNot:   t = {ci, ~a};
      OpCmp:   t = {(a < b), prev};
      default: t = {ci, prev};
    endcase
    return t;
  endfunction

  always @(posedge clk) begin
    if (alu_enable) {alu_c_m, alu_out_m} <= alu_eval(alu_opcode, alu_in_a, alu_in_b, alu_c_m,
                                                     alu_out_m);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic [4:0] op, input logic [15:0] a, b);
    req_opcode[idx*5 +: 5] = op;
    req_a[idx*16 +: 16]    = a;
    req_b[idx*16 +: 16]    = b;
  endtask

  // Called at a negedge in IDLE with inputs set; returns at the RESP sample point.
  task automatic serve(input int idx, input bit drop, input logic [15:0] d,
                       input logic c, z, s);
    logic [1:0] oh;
    oh = 2'b01 << idx;
    #1 check("grant", 32'(req_ready), 32'(oh));
    @(negedge clk);
    if (drop) req_valid[idx] = 1'b0;
    #1 check("issue_en", 32'(alu_enable), 32'd1);
    check("issue_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    #1 check("capture_en", 32'(alu_enable), 32'd0);
    @(negedge clk);
    #1 check("rsp_valid", 32'(rsp_valid), 32'(oh));
    check("rsp_data", 32'(rsp_data), 32'(d));
    check("rsp_c", 32'(rsp_cflag), 32'(c));
    check("rsp_z", 32'(rsp_zflag), 32'(z));
    check("rsp_s", 32'(rsp_sflag), 32'(s));
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 2'b11;
    req_opcode = '0;
    req_a = '0;
    req_b = '0;
    req_lock = '0;
    repeat (2) @(negedge clk);
    #1 check("rst_alu_enable", 32'(alu_enable), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_alu_opcode", 32'(alu_opcode), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("idle_no_req", 32'(req_ready), 32'd0);

    // Single request: ADD 3+4
    @(negedge clk);
    req_valid = 2'b01;
    set_req(0, OpAdd, 16'h0003, 16'h0004);
    serve(0, 1'b1, 16'h0007, 1'b0, 1'b0, 1'b0);

    // req1 alone moves the pointer back to 0
    @(negedge clk);
    req_valid = 2'b10;
    set_req(1, OpAnd, 16'h00FF, 16'h0F0F);
    serve(1, 1'b1, 16'h000F, 1'b0, 1'b0, 1'b0);

    // Both requesting continuously: grants alternate starting with req0
    @(negedge clk);
    req_valid = 2'b11;
    set_req(0, OpSub, 16'h0005, 16'h0005);
    set_req(1, OpInc, 16'hFFFF, 16'h0000);
    for (int k = 0; k < 8; k++) begin
      if (k != 0) @(negedge clk);
      if (k % 2 == 0) serve(0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
      else            serve(1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    end

    // Response backpressure on req1 while req0 waits
    @(negedge clk);
    req_valid = 2'b10;
    rsp_ready = 2'b01;
    set_req(1, OpOr, 16'h1200, 16'h0034);
    serve(1, 1'b1, 16'h1234, 1'b1, 1'b0, 1'b0);
    set_req(0, OpAdd, 16'h7FFF, 16'h0001);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      req_valid[0] = 1'b1;
      #1 check("bp_rsp_valid", 32'(rsp_valid), 32'b10);
      check("bp_rsp_data", 32'(rsp_data), 32'h1234);
      check("bp_req_ready", 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    rsp_ready = 2'b11;
    @(negedge clk);
    serve(0, 1'b1, 16'h8000, 1'b0, 1'b0, 1'b1);

    // Reset during CAPTURE of a req1 op
    @(negedge clk);
    req_valid = 2'b10;
    set_req(1, OpAnd, 16'h1111, 16'h0101);
    #1 check("rst_test_grant", 32'(req_ready), 32'b10);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b0;
    #1 check("mid_rst_alu_enable", 32'(alu_enable), 32'd0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_rsp_data", 32'(rsp_data), 32'd0);
    check("mid_rst_alu_in_a", 32'(alu_in_a), 32'd0);
    check("mid_rst_alu_opcode", 32'(alu_opcode), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 2'b11;
    set_req(0, OpSub, 16'h0003, 16'h0005);
    #1 check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    #0 serve(0, 1'b1, 16'hFFFE, 1'b1, 1'b0, 1'b1);

    // Sign flag with carry carried over from the SUB borrow
    @(negedge clk);
    req_valid = 2'b01;
    set_req(0, OpXor, 16'h8000, 16'h0000);
    serve(0, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1);

    // Carry chain: ADD with lock, then ADC competing with req1
    @(negedge clk);
    set_req(0, OpAdd, 16'hFFFF, 16'h0001);
    req_lock = 2'b01;
    serve(0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    req_valid = 2'b11;
    req_lock = 2'b00;
    set_req(0, OpAdc, 16'h0000, 16'h0000);
    set_req(1, OpAnd, 16'hFFFF, 16'h00F0);
    @(negedge clk);
`ifdef ALU_LOCK_EN
    serve(0, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    serve(1, 1'b1, 16'h00F0, 1'b0, 1'b0, 1'b0);
`else
    serve(1, 1'b1, 16'h00F0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    serve(0, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
`endif
    @(negedge clk);
    req_valid = 2'b00;
    repeat (3) @(negedge clk);
    #1 check("end_idle_rsp_valid", 32'(rsp_valid), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
